// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: access sizes, pipeline states and
// the lane-index width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Number of address bits that select a byte lane within one data word.
  function automatic int lane_bits(input int dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extractor: shifts the addressed bytes of a read word down
// to bit 0 and sign/zero-extends them to the full data width.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = lane_bits(DW)
) (
  input  logic [DW-1:0] rdata,
  input  logic [LW-1:0] lane,
  input  size_e         size,
  input  logic          is_unsigned,
  output logic [DW-1:0] ext
);

  logic [DW-1:0] shifted;
  int            msb;
  logic          sign;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SZ_B:    msb = 7;
      SZ_H:    msb = 15;
      SZ_W:    msb = 31;
      default: msb = DW - 1;
    endcase
    sign = shifted[msb];
    ext  = '0;
    for (int i = 0; i < DW; i++) begin
      ext[i] = (i <= msb) ? shifted[i] : (sign & ~is_unsigned);
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage between execute and writeback; drives the data SRAM.
// Optional MEM_ALIGN_EXC_EN turns misaligned accesses into exception entries.
//
// state | meaning
// EMPTY | output buffer free, ready for a new op
// WAIT  | load issued, counting down the SRAM read latency
// FULL  | output buffer holds a result for writeback
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1,
  parameter int RW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mem_en,
  input  logic            in_is_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [AW-1:0]   in_addr,
  input  logic [DW-1:0]   in_wdata,
  input  logic [DW-1:0]   in_result,
  input  logic [RW-1:0]   in_dest,
  output logic            data_sram_en,
  output logic [DW/8-1:0] data_sram_wen,
  output logic [AW-1:0]   data_sram_addr,
  output logic [DW-1:0]   data_sram_wdata,
  input  logic [DW-1:0]   data_sram_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [RW-1:0]   out_dest,
  output logic            out_exc
);

  localparam int NB = DW / 8;
  localparam int LW = lane_bits(DW);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          acc, mis, mem_go, ld_go;
  size_e         size_eff;
  logic [LW-1:0] lane, size_mask, alane;
  logic [NB-1:0] strobe;
  logic [DW-1:0] wdata_rep, ld_ext;
  logic [LW-1:0] ld_lane_q;
  size_e         ld_size_q;
  logic          ld_uns_q;

  assign in_ready  = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
  // Gating with reset keeps the SRAM quiet while reset is held.
  assign acc       = in_valid & in_ready & ~reset;
  assign out_valid = (state_q == FULL);

  always_comb begin
    size_eff = size_e'(in_size);
    if (DW == 32 && size_eff == SZ_D) size_eff = SZ_W;
    case (size_eff)
      SZ_B:    size_mask = '0;
      SZ_H:    size_mask = LW'(1);
      SZ_W:    size_mask = LW'(3);
      default: size_mask = LW'(7);
    endcase
    lane  = in_addr[LW-1:0];
    alane = lane & ~size_mask;
  end

`ifdef MEM_ALIGN_EXC_EN
  assign mis = in_mem_en & (|(lane & size_mask));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    case (size_eff)
      SZ_B: begin
        strobe    = NB'(1) << alane;
        wdata_rep = {NB{in_wdata[7:0]}};
      end
      SZ_H: begin
        strobe    = NB'(3) << alane;
        wdata_rep = {(NB/2){in_wdata[15:0]}};
      end
      SZ_W: begin
        strobe    = NB'(15) << alane;
        wdata_rep = {(NB/4){in_wdata[31:0]}};
      end
      default: begin
        strobe    = '1;
        wdata_rep = in_wdata;
      end
    endcase
  end

  assign mem_go          = acc & in_mem_en & ~mis;
  assign ld_go           = mem_go & ~in_is_store;
  assign data_sram_en    = mem_go;
  assign data_sram_wen   = (mem_go & in_is_store) ? strobe : '0;
  assign data_sram_addr  = mem_go ? {in_addr[AW-1:LW], {LW{1'b0}}} : '0;
  assign data_sram_wdata = (mem_go & in_is_store) ? wdata_rep : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY, FULL: begin
        if (acc) begin
          if (ld_go) begin
            state_d = WAIT;
            cnt_d   = 2'(RD_LAT - 1);
          end else begin
            state_d = FULL;
          end
        end else if (state_q == FULL && out_ready) begin
          state_d = EMPTY;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = FULL;
        else             cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_load_align #(.DW(DW), .LW(LW)) u_align (
    .rdata       (data_sram_rdata),
    .lane        (ld_lane_q),
    .size        (ld_size_q),
    .is_unsigned (ld_uns_q),
    .ext         (ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_dest  <= '0;
      out_exc   <= 1'b0;
      ld_lane_q <= '0;
      ld_size_q <= SZ_B;
      ld_uns_q  <= 1'b0;
    end else if (acc) begin
      out_dest <= in_dest;
      out_exc  <= mis;
      if (ld_go) begin
        ld_lane_q <= alane;
        ld_size_q <= size_eff;
        ld_uns_q  <= in_unsigned;
      end else begin
        out_data <= mis ? DW'(in_addr) : in_result;
      end
    end else if (state_q == WAIT && cnt_q == '0) begin
      out_data <= ld_ext;
    end else if (state_q == FULL && out_ready) begin
      out_exc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (DW=32, RD_LAT=2): vector table plus
// hand-written backpressure, streaming and reset-in-WAIT sequences.
module tb_mem_stage_lsu;

  localparam int AW = 32, DW = 32, RD_LAT = 2, RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid, in_ready, in_mem_en, in_is_store, in_unsigned;
  logic [1:0]    in_size;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata, in_result;
  logic [RW-1:0] in_dest;
  logic          data_sram_en;
  logic [3:0]    data_sram_wen;
  logic [AW-1:0] data_sram_addr;
  logic [DW-1:0] data_sram_wdata, data_sram_rdata;
  logic          out_valid, out_ready, out_exc;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_dest;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mem_en(in_mem_en),
    .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result), .in_dest(in_dest),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_exc(out_exc)
  );

  // SRAM model: read data valid exactly RD_LAT cycles after the request, junk otherwise.
  logic [31:0]       mem [0:255];
  logic [31:0]       rd_pipe [0:RD_LAT-1];
  logic [RD_LAT-1:0] rd_v = '0;

  always @(posedge clk) begin
    rd_pipe[0] <= mem[data_sram_addr[9:2]];
    rd_v[0]    <= data_sram_en && (data_sram_wen == 4'b0000);
    for (int i = 1; i < RD_LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_v[i]    <= rd_v[i-1];
    end
  end

  assign data_sram_rdata = rd_v[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hDEADBEEF;

  typedef struct {
    logic        mem_en, st, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, result, pre;
    logic [4:0]  dest;
    logic        exp_en;
    logic [3:0]  exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic        exp_exc;
  } vec_t;

  function automatic vec_t mk(input logic me, st, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, wdata, result, pre,
                              input logic en, input logic [3:0] wen,
                              input logic [31:0] eaddr, ewdata, edata, input logic eexc);
    vec_t v;
    v.mem_en = me; v.st = st; v.sz = sz; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.result = result; v.pre = pre; v.dest = 5'd0;
    v.exp_en = en; v.exp_wen = wen; v.exp_addr = eaddr; v.exp_wdata = ewdata;
    v.exp_data = edata; v.exp_exc = eexc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int lat;
    lat = (v.exp_en && v.exp_wen == 4'b0000) ? RD_LAT + 1 : 1;
    tick();
    mem[v.addr[9:2]] = v.pre;
    in_valid = 1'b1; in_mem_en = v.mem_en; in_is_store = v.st; in_size = v.sz;
    in_unsigned = v.uns; in_addr = v.addr; in_wdata = v.wdata; in_result = v.result;
    in_dest = v.dest;
    #1;
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".en"}, data_sram_en, v.exp_en);
    chk({tag, ".wen"}, data_sram_wen, v.exp_wen);
    chk({tag, ".addr"}, data_sram_addr, v.exp_addr);
    chk({tag, ".wdata"}, data_sram_wdata, v.exp_wdata);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      chk({tag, ".wait_ready"}, in_ready, 0);
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".data"}, out_data, v.exp_data);
    chk({tag, ".dest"}, out_dest, v.dest);
    chk({tag, ".exc"}, out_exc, v.exp_exc);
  endtask

  vec_t vecs [12];

  initial begin
    in_valid = 1'b1; in_mem_en = 1'b1; in_is_store = 1'b1; in_size = 2'd2;
    in_unsigned = 1'b0; in_addr = 32'h1000; in_wdata = 32'h12345678;
    in_result = 32'h0; in_dest = 5'd9; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_dest", out_dest, 0);
    chk("rst.out_exc", out_exc, 0);
    chk("rst.sram_en", data_sram_en, 0);
    chk("rst.sram_wen", data_sram_wen, 0);
    chk("rst.sram_addr", data_sram_addr, 0);
    in_valid = 1'b0;
    reset = 1'b0;

    //            me  st  sz   uns addr          wdata         result        pre           en  wen      eaddr         ewdata        edata         exc
    vecs[0]  = mk(1, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB, 32'h1111_1111, 32'h0,        1, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB, 32'h1111_1111, 0);
    vecs[1]  = mk(1, 0, 2'd1, 0, 32'h0000_2002, 32'h0,         32'hEEEE_EEEE, 32'h8001_1234, 1, 4'b0000, 32'h0000_2000, 32'h0,         32'hFFFF_8001, 0);
    vecs[2]  = mk(1, 0, 2'd1, 1, 32'h0000_2002, 32'h0,         32'hEEEE_EEEE, 32'h8001_1234, 1, 4'b0000, 32'h0000_2000, 32'h0,         32'h0000_8001, 0);
    vecs[3]  = mk(1, 0, 2'd0, 0, 32'h0000_2001, 32'h0,         32'hEEEE_EEEE, 32'h1122_9C44, 1, 4'b0000, 32'h0000_2000, 32'h0,         32'hFFFF_FF9C, 0);
    vecs[4]  = mk(1, 0, 2'd0, 1, 32'h0000_2003, 32'h0,         32'hEEEE_EEEE, 32'hF122_9C44, 1, 4'b0000, 32'h0000_2000, 32'h0,         32'h0000_00F1, 0);
    vecs[5]  = mk(1, 0, 2'd2, 0, 32'h0000_2004, 32'h0,         32'hEEEE_EEEE, 32'hCAFE_BABE, 1, 4'b0000, 32'h0000_2004, 32'h0,         32'hCAFE_BABE, 0);
    vecs[6]  = mk(1, 1, 2'd1, 0, 32'h0000_1002, 32'h0000_BEEF, 32'h2222_2222, 32'h0,        1, 4'b1100, 32'h0000_1000, 32'hBEEF_BEEF, 32'h2222_2222, 0);
    vecs[7]  = mk(1, 1, 2'd2, 0, 32'h0000_1004, 32'h1234_5678, 32'h3333_3333, 32'h0,        1, 4'b1111, 32'h0000_1004, 32'h1234_5678, 32'h3333_3333, 0);
    vecs[8]  = mk(0, 0, 2'd2, 0, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_5A5A, 32'h0,        0, 4'b0000, 32'h0,         32'h0,         32'h0000_5A5A, 0);
    vecs[9]  = mk(1, 1, 2'd3, 0, 32'h0000_1008, 32'h0BAD_F00D, 32'h4444_4444, 32'h0,        1, 4'b1111, 32'h0000_1008, 32'h0BAD_F00D, 32'h4444_4444, 0);
`ifdef MEM_ALIGN_EXC_EN
    vecs[10] = mk(1, 0, 2'd2, 0, 32'h0000_3002, 32'h0,         32'hEEEE_EEEE, 32'h5566_7788, 0, 4'b0000, 32'h0,         32'h0,         32'h0000_3002, 1);
`else
    vecs[10] = mk(1, 0, 2'd2, 0, 32'h0000_3002, 32'h0,         32'hEEEE_EEEE, 32'h5566_7788, 1, 4'b0000, 32'h0000_3000, 32'h0,         32'h5566_7788, 0);
`endif
    vecs[11] = mk(1, 0, 2'd1, 0, 32'h0000_2000, 32'h0,         32'hEEEE_EEEE, 32'hFFFF_7FFF, 1, 4'b0000, 32'h0000_2000, 32'h0,         32'h0000_7FFF, 0);

    for (int i = 0; i < 12; i++) begin
      vecs[i].dest = 5'(i + 1);
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Backpressure: A sits in FULL, B is held off until out_ready returns.
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_mem_en = 1'b0;
    in_result = 32'hA1; in_dest = 5'd1;
    tick();
    in_result = 32'hB2; in_dest = 5'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp.ready%0d", k), in_ready, 0);
      chk($sformatf("bp.valid%0d", k), out_valid, 1);
      chk($sformatf("bp.dataA%0d", k), out_data, 32'hA1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp.validB", out_valid, 1);
    chk("bp.dataB", out_data, 32'hB2);
    chk("bp.destB", out_dest, 2);
    tick();
    chk("bp.drained", out_valid, 0);

    // Streaming non-memory ops at one per cycle.
    in_valid = 1'b1; in_mem_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_result = 32'(k); in_dest = 5'(k);
      #1;
      chk($sformatf("b2b.ready%0d", k), in_ready, 1);
      tick();
      chk($sformatf("b2b.valid%0d", k), out_valid, 1);
      chk($sformatf("b2b.data%0d", k), out_data, 32'(k));
    end
    in_valid = 1'b0;
    tick();

    // Reset while a load waits on the SRAM.
    mem[0] = 32'h8001_1234;
    in_valid = 1'b1; in_mem_en = 1'b1; in_is_store = 1'b0; in_size = 2'd1;
    in_unsigned = 1'b0; in_addr = 32'h2002; in_dest = 5'd7;
    tick();
    in_valid = 1'b0;
    #1;
    chk("rw.in_wait", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rw.out_valid", out_valid, 0);
    chk("rw.out_data", out_data, 0);
    in_valid = 1'b1;
    #1;
    chk("rw.sram_en", data_sram_en, 0);
    chk("rw.sram_addr", data_sram_addr, 0);
    tick();
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rw.idle1", out_valid, 0);
    tick();
    chk("rw.idle2", out_valid, 0);
    vecs[0] = mk(1, 0, 2'd1, 1, 32'h0000_2000, 32'h0, 32'hEEEE_EEEE, 32'h7654_3210,
                 1, 4'b0000, 32'h0000_2000, 32'h0, 32'h0000_3210, 0);
    vecs[0].dest = 5'd12;
    run_vec(vecs[0], "rw.after");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
